// File: rtl/ddr2_init_seq_if.sv
// DDR2 command/address pin bundle driven by the power-up init sequencer.
//   cke                       clock enable
//   csbar/rasbar/casbar/webar command pins
//   ba[1:0], a[12:0]          bank / address (mode register value during MRS)
//   odt                       on-die termination
//   init_done                 sequence complete
// master: the sequencer (drives everything); slave: the pin mux / DRAM side.
interface ddr2_init_seq_if;
    logic        cke;
    logic        csbar;
    logic        rasbar;
    logic        casbar;
    logic        webar;
    logic [1:0]  ba;
    logic [12:0] a;
    logic        odt;
    logic        init_done;

    modport master (
        output cke, csbar, rasbar, casbar, webar, ba, a, odt, init_done
    );

    modport slave (
        input cke, csbar, rasbar, casbar, webar, ba, a, odt, init_done
    );
endinterface

// File: rtl/ddr2_init_seq.sv
// DDR2 (512 Mb x16) JEDEC power-up initialization sequencer.
// Walks PWRUP -> CKEON -> PALL -> EMR2 -> EMR3 -> EMR1 -> MR(DLL reset) -> PALL
// -> REF -> REF -> MR -> EMR1(OCD default) -> EMR1(OCD exit) -> DLL wait -> DONE.
// Ports:
//   ck        clock; all pin outputs registered on its rising edge
//   resetbar  synchronous active-low reset; restarts the sequence from PWRUP
//   dram      master modport of ddr2_init_seq_if (command/address/cke/odt/init_done)
module ddr2_init_seq #(
    parameter int unsigned T_PWRUP = 53334,
    parameter int unsigned T_NOP   = 107,
    parameter int unsigned T_RP    = 4,
    parameter int unsigned T_MRD   = 2,
    parameter int unsigned T_RFC   = 28,
    parameter int unsigned T_DLL   = 200,
    parameter int unsigned CL      = 4,
    parameter int unsigned BL      = 4,
    parameter int unsigned AL      = 0,
    parameter int unsigned WR      = 4
) (
    input  logic                 ck,
    input  logic                 resetbar,
    ddr2_init_seq_if.master      dram
);

    function automatic int unsigned max2(input int unsigned x, input int unsigned y);
        return (x > y) ? x : y;
    endfunction

    localparam int unsigned T_MAX = max2(max2(max2(T_PWRUP, T_NOP), max2(T_RP, T_MRD)),
                                         max2(T_RFC, T_DLL));
    localparam int unsigned CW    = (T_MAX < 2) ? 1 : $clog2(T_MAX + 1);

    // {csbar, rasbar, casbar, webar}
    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PALL  = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    // Mode register images
    localparam logic [2:0]  BL_CODE   = (BL == 8) ? 3'b011 : 3'b010;
    localparam logic [12:0] MR_BASE   = {1'b0, 3'(WR - 1), 1'b0, 1'b0, 3'(CL), 1'b0, BL_CODE};
    localparam logic [12:0] MR_DLL    = MR_BASE | 13'h0100;
    localparam logic [12:0] EMR1_BASE = {3'b000, 3'b000, 1'b0, 3'(AL), 3'b000};
    localparam logic [12:0] EMR1_OCD  = EMR1_BASE | 13'h0380;
    localparam logic [12:0] A_PALL    = 13'h0400;

    typedef enum logic [3:0] {
        S_PWRUP, S_CKEON, S_PALL1, S_EMR2, S_EMR3, S_EMR1, S_MRDLL, S_PALL2,
        S_REF1, S_REF2, S_MR, S_OCDDEF, S_OCDEXIT, S_DLLWAIT, S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;     // cycles already emitted in the current step
    logic [CW-1:0]  dll_q, dll_d;     // cycles since the DLL-reset MRS, saturating
    logic           cke_q, cke_d;
    logic [3:0]     cmd_q, cmd_d;
    logic [1:0]     ba_q, ba_d;
    logic [12:0]    a_q, a_d;
    logic           done_q, done_d;

    state_e         nxt;
    logic [CW-1:0]  dur;
    logic           timed;
    logic           dll_expired;
    logic           first;

    // State and pin registers
    always_ff @(posedge ck) begin
        if (!resetbar) begin
            state_q <= S_PWRUP;
            cnt_q   <= '0;
            dll_q   <= '0;
            cke_q   <= 1'b0;
            cmd_q   <= CMD_DESEL;
            ba_q    <= 2'b00;
            a_q     <= 13'h0000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dll_q   <= dll_d;
            cke_q   <= cke_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            a_q     <= a_d;
            done_q  <= done_d;
        end
    end

    // Next step, next pin values and DLL counter
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        dll_d       = dll_q;
        cke_d       = 1'b1;
        cmd_d       = CMD_NOP;
        ba_d        = 2'b00;
        a_d         = 13'h0000;
        done_d      = 1'b0;
        nxt         = S_DONE;
        dur         = '0;
        timed       = 1'b1;
        dll_expired = (dll_q >= CW'(T_DLL));
        first       = 1'b0;

        // Length of the current step and its successor
        case (state_q)
            S_PWRUP:   begin dur = CW'(T_PWRUP); nxt = S_CKEON;   end
            S_CKEON:   begin dur = CW'(T_NOP);   nxt = S_PALL1;   end
            S_PALL1:   begin dur = CW'(T_RP);    nxt = S_EMR2;    end
            S_EMR2:    begin dur = CW'(T_MRD);   nxt = S_EMR3;    end
            S_EMR3:    begin dur = CW'(T_MRD);   nxt = S_EMR1;    end
            S_EMR1:    begin dur = CW'(T_MRD);   nxt = S_MRDLL;   end
            S_MRDLL:   begin dur = CW'(T_MRD);   nxt = S_PALL2;   end
            S_PALL2:   begin dur = CW'(T_RP);    nxt = S_REF1;    end
            S_REF1:    begin dur = CW'(T_RFC);   nxt = S_REF2;    end
            S_REF2:    begin dur = CW'(T_RFC);   nxt = S_MR;      end
            S_MR:      begin dur = CW'(T_MRD);   nxt = S_OCDDEF;  end
            S_OCDDEF:  begin dur = CW'(T_MRD);   nxt = S_OCDEXIT; end
            // DLL wait is skipped entirely when the DLL counter already expired
            S_OCDEXIT: begin
                dur = CW'(T_MRD);
                nxt = dll_expired ? S_DONE : S_DLLWAIT;
            end
            default:   timed = 1'b0;
        endcase

        if (timed) begin
            if (cnt_q == dur) begin
                state_d = nxt;
                cnt_d   = CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
            if (state_q == S_DLLWAIT && dll_expired) begin
                state_d = S_DONE;
            end
        end

        // Commands occupy only the first cycle of their step; NOP fills the wait
        first = (cnt_d == CW'(1));
        case (state_d)
            S_PWRUP: begin
                cke_d = 1'b0;
                cmd_d = CMD_DESEL;
            end
            S_PALL1, S_PALL2: if (first) begin
                cmd_d = CMD_PALL;
                a_d   = A_PALL;
            end
            S_EMR2: if (first) begin
                cmd_d = CMD_MRS;
                ba_d  = 2'b10;
            end
            S_EMR3: if (first) begin
                cmd_d = CMD_MRS;
                ba_d  = 2'b11;
            end
            S_EMR1, S_OCDEXIT: if (first) begin
                cmd_d = CMD_MRS;
                ba_d  = 2'b01;
                a_d   = EMR1_BASE;
            end
            S_OCDDEF: if (first) begin
                cmd_d = CMD_MRS;
                ba_d  = 2'b01;
                a_d   = EMR1_OCD;
            end
            S_MRDLL: if (first) begin
                cmd_d = CMD_MRS;
                a_d   = MR_DLL;
            end
            S_MR: if (first) begin
                cmd_d = CMD_MRS;
                a_d   = MR_BASE;
            end
            S_REF1, S_REF2: if (first) begin
                cmd_d = CMD_REF;
            end
            S_DONE: done_d = 1'b1;
            default: ;
        endcase

        // DLL counter starts with the DLL-reset MRS and saturates at T_DLL
        if (state_d == S_MRDLL && first) begin
            dll_d = CW'(1);
        end else if (dll_q != '0 && !dll_expired) begin
            dll_d = dll_q + CW'(1);
        end
    end

    assign dram.cke       = cke_q;
    assign dram.csbar     = cmd_q[3];
    assign dram.rasbar    = cmd_q[2];
    assign dram.casbar    = cmd_q[1];
    assign dram.webar     = cmd_q[0];
    assign dram.ba        = ba_q;
    assign dram.a         = a_q;
    assign dram.odt       = 1'b0;
    assign dram.init_done = done_q;

endmodule

// File: tb/tb_ddr2_init_seq.sv
// Self-checking bench for ddr2_init_seq: three instances (default modes,
// BL8/CL3/AL2, short T_DLL) share clock and a randomly pulsed reset; every
// cycle each instance's pins are compared to a schedule-based reference model.
module tb_ddr2_init_seq;

    localparam int TP   = 10;
    localparam int TN   = 5;
    localparam int TRP  = 4;
    localparam int TMRD = 2;
    localparam int TRFC = 28;
    localparam int WRV  = 4;

    typedef struct packed {
        logic        cke;
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] a;
        logic        odt;
        logic        done;
    } pins_t;

    logic ck;
    logic resetbar;
    int   cyc      = -1;
    int   run_id   = 0;
    bit   started  = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    ddr2_init_seq_if if_a ();
    ddr2_init_seq_if if_b ();
    ddr2_init_seq_if if_c ();

    ddr2_init_seq #(.T_PWRUP(TP), .T_NOP(TN), .T_RP(TRP), .T_MRD(TMRD), .T_RFC(TRFC),
                    .T_DLL(200), .CL(4), .BL(4), .AL(0), .WR(WRV))
        dut_a (.ck(ck), .resetbar(resetbar), .dram(if_a));

    ddr2_init_seq #(.T_PWRUP(TP), .T_NOP(TN), .T_RP(TRP), .T_MRD(TMRD), .T_RFC(TRFC),
                    .T_DLL(200), .CL(3), .BL(8), .AL(2), .WR(WRV))
        dut_b (.ck(ck), .resetbar(resetbar), .dram(if_b));

    ddr2_init_seq #(.T_PWRUP(TP), .T_NOP(TN), .T_RP(TRP), .T_MRD(TMRD), .T_RFC(TRFC),
                    .T_DLL(10), .CL(4), .BL(4), .AL(0), .WR(WRV))
        dut_c (.ck(ck), .resetbar(resetbar), .dram(if_c));

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Cycle index relative to the last reset release (-1 while in reset)
    always @(posedge ck) begin
        started <= 1'b1;
        if (!resetbar) cyc <= -1;
        else           cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s run=%0d cyc=%0d got=0x%0h exp=0x%0h", tag, run_id, cyc, got, exp);
        end
    endtask

    // Reference: command schedule derived from the wait list, pins from cycle index
    function automatic pins_t model(input int k, input int t_dll, input int bl,
                                    input int cl, input int al);
        pins_t p;
        int    at[11];
        int    w[10];
        int    t_done;
        int    mr;
        int    emr1;
        p     = '0;
        p.cmd = 4'b1111;
        if (k < 0) return p;
        w = '{TRP, TMRD, TMRD, TMRD, TMRD, TRP, TRFC, TRFC, TMRD, TMRD};
        at[0] = TP + TN;
        for (int i = 1; i < 11; i++) at[i] = at[i-1] + w[i-1];
        t_done = (at[10] + TMRD > at[4] + t_dll) ? at[10] + TMRD : at[4] + t_dll;
        mr   = ((WRV - 1) << 9) | (cl << 4) | ((bl == 8) ? 3 : 2);
        emr1 = al << 3;
        p.cke  = (k >= TP);
        p.done = (k >= t_done);
        if (k >= TP) p.cmd = 4'b0111;
        for (int i = 0; i < 11; i++) begin
            if (k == at[i]) begin
                case (i)
                    0, 5: begin p.cmd = 4'b0010; p.a = 13'h0400; end
                    1:    begin p.cmd = 4'b0000; p.ba = 2'd2; end
                    2:    begin p.cmd = 4'b0000; p.ba = 2'd3; end
                    3, 10: begin p.cmd = 4'b0000; p.ba = 2'd1; p.a = 13'(emr1); end
                    4:    begin p.cmd = 4'b0000; p.a = 13'(mr | 'h100); end
                    6, 7: p.cmd = 4'b0001;
                    8:    begin p.cmd = 4'b0000; p.a = 13'(mr); end
                    default: begin p.cmd = 4'b0000; p.ba = 2'd1; p.a = 13'(emr1 | 'h380); end
                endcase
            end
        end
        return p;
    endfunction

    pins_t got_a, got_b, got_c;
    assign got_a = {if_a.cke, if_a.csbar, if_a.rasbar, if_a.casbar, if_a.webar,
                    if_a.ba, if_a.a, if_a.odt, if_a.init_done};
    assign got_b = {if_b.cke, if_b.csbar, if_b.rasbar, if_b.casbar, if_b.webar,
                    if_b.ba, if_b.a, if_b.odt, if_b.init_done};
    assign got_c = {if_c.cke, if_c.csbar, if_c.rasbar, if_c.casbar, if_c.webar,
                    if_c.ba, if_c.a, if_c.odt, if_c.init_done};

    always @(negedge ck) begin
        if (started) begin
            check_eq("A_pins", 32'(got_a), 32'(model(cyc, 200, 4, 4, 0)));
            check_eq("B_pins", 32'(got_b), 32'(model(cyc, 200, 8, 3, 2)));
            check_eq("C_pins", 32'(got_c), 32'(model(cyc, 10, 4, 4, 0)));
            // Independent spot values on the first full sequence
            if (run_id == 1) begin
                case (cyc)
                    9:   check_eq("A_cke_low",   32'(if_a.cke), 32'd0);
                    10:  check_eq("A_cke_rise",  32'(if_a.cke), 32'd1);
                    15:  check_eq("A_pall1_cmd", 32'({if_a.csbar, if_a.rasbar, if_a.casbar, if_a.webar}), 32'h2);
                    23:  check_eq("B_emr1",      32'(if_b.a), 32'h0010);
                    25:  check_eq("A_mrdll",     32'(if_a.a), 32'h0742);
                    87: begin
                         check_eq("A_mr",        32'(if_a.a), 32'h0642);
                         check_eq("B_mr",        32'(if_b.a), 32'h0633);
                    end
                    89:  check_eq("A_ocddef",    32'(if_a.a), 32'h0380);
                    91:  check_eq("A_ocdexit",   32'({if_a.ba, if_a.a}), 32'h2000);
                    92:  check_eq("C_done_early", 32'(if_c.init_done), 32'd0);
                    93:  check_eq("C_done",      32'(if_c.init_done), 32'd1);
                    224: check_eq("A_done_early", 32'(if_a.init_done), 32'd0);
                    225: check_eq("A_done",      32'(if_a.init_done), 32'd1);
                    default: ;
                endcase
            end
        end
    end

    // Run n cycles from the current release, then hold reset for 'low' cycles
    task automatic pulse(input int n, input int low);
        repeat (n) @(posedge ck);
        #1 resetbar = 1'b0;
        repeat (low) @(posedge ck);
        #1 resetbar = 1'b1;
        run_id++;
    endtask

    initial begin
        resetbar = 1'b0;
        repeat (3) @(posedge ck);
        #1 resetbar = 1'b1;
        run_id = 1;
        pulse(240, 1);                 // full sequence, then reset after DONE
        pulse(60, 1);                  // reset sampled low at cycle 60
        for (int i = 0; i < 6; i++) begin
            pulse(int'($urandom_range(1, 260)), int'($urandom_range(1, 3)));
        end
        repeat (240) @(posedge ck);
        @(negedge ck);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
